// File: rtl/serial_tx_scheduler.sv
// Round-robin byte scheduler feeding one MSB-first serial shifter,
// with an overlapping "1101" detector and saturating match counter.
module serial_tx_scheduler #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int CNTW = 8,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int BW  = (DW > 1) ? $clog2(DW) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   data_flat,
    input  logic                 clr_cnt,
    output logic [NREQ-1:0]      gnt,
    output logic [IW-1:0]        frame_src,
    output logic                 busy,
    output logic                 ser_out,
    output logic                 ser_valid,
    output logic                 frame_done,
    output logic                 match,
    output logic [CNTW-1:0]      match_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } det_t;

    localparam logic [BW-1:0] LAST = BW'(DW - 1);

    state_t          state_q;
    det_t            det_q;
    det_t            det_d;
    logic [DW-1:0]   shreg_q;
    logic [BW-1:0]   bit_cnt_q;
    logic [IW-1:0]   rr_q;
    logic [NREQ-1:0] gnt_q;
    logic [IW-1:0]   src_q;
    logic            match_q;
    logic [CNTW-1:0] cnt_q;
    logic            pick_vld;
    logic [IW-1:0]   pick_idx;

    function automatic logic [IW-1:0] rr_add(input logic [IW-1:0] base, input int off);
        int s;
        s = (int'(base) + off) % NREQ;
        return IW'(s);
    endfunction

    // First set request at or after rr_q, wrapping around.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!pick_vld && req[rr_add(rr_q, i)]) begin
                pick_vld = 1'b1;
                pick_idx = rr_add(rr_q, i);
            end
        end
    end

    always_comb begin
        det_d = S0;
        unique case (det_q)
            S0:      det_d = ser_out ? S1 : S0;
            S1:      det_d = ser_out ? S2 : S0;
            S2:      det_d = ser_out ? S2 : S3;
            S3:      det_d = ser_out ? S4 : S0;
            S4:      det_d = ser_out ? S2 : S0;
            default: det_d = S0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            rr_q      <= '0;
            det_q     <= S0;
            gnt_q     <= '0;
            src_q     <= '0;
            match_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            gnt_q   <= '0;
            match_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        shreg_q         <= data_flat[int'(pick_idx)*DW +: DW];
                        bit_cnt_q       <= '0;
                        det_q           <= S0;
                        src_q           <= pick_idx;
                        rr_q            <= rr_add(pick_idx, 1);
                        gnt_q[pick_idx] <= 1'b1;
                        state_q         <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        shreg_q   <= shreg_q << 1;
                        bit_cnt_q <= bit_cnt_q + BW'(1);
                        det_q     <= det_d;
                        match_q   <= (det_d == S4);
                        if (bit_cnt_q == LAST) state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            // Clear has priority over a coincident match pulse.
            if (clr_cnt) cnt_q <= '0;
            else if (match_q && cnt_q != '1) cnt_q <= cnt_q + CNTW'(1);
        end
    end

    assign gnt        = gnt_q;
    assign frame_src  = src_q;
    assign busy       = (state_q != IDLE);
    assign ser_out    = shreg_q[DW-1];
    assign ser_valid  = (state_q == SHIFT) && tick;
    assign frame_done = (state_q == DONE);
    assign match      = match_q;
    assign match_cnt  = cnt_q;

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Directed + randomized bench for serial_tx_scheduler against a
// frame-level reference (round-robin order, sliding-window pattern search).
module tb_serial_tx_scheduler;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int CNTW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            tick = 1'b0;
    logic            clr_cnt = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic [NREQ*DW-1:0] data_flat = '0;
    logic [NREQ-1:0] gnt;
    logic [1:0]      frame_src;
    logic            busy;
    logic            ser_out;
    logic            ser_valid;
    logic            frame_done;
    logic            match;
    logic [CNTW-1:0] match_cnt;

    serial_tx_scheduler #(.NREQ(NREQ), .DW(DW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .tick(tick), .req(req),
        .data_flat(data_flat), .clr_cnt(clr_cnt), .gnt(gnt),
        .frame_src(frame_src), .busy(busy), .ser_out(ser_out),
        .ser_valid(ser_valid), .frame_done(frame_done),
        .match(match), .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    bit exp_match = 0;
    bit pend_match = 0;
    int rr = 0;
    bit clr_on_match = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge; the counter model follows the visible match pulse.
    task automatic clk_step();
        clr_cnt = clr_on_match && exp_match;
        @(posedge clk);
        if (clr_cnt) exp_cnt = 0;
        else if (exp_match && exp_cnt < 255) exp_cnt++;
        exp_match = pend_match;
        pend_match = 0;
        #1;
        clr_cnt = 1'b0;
        chk("match", match, exp_match);
        chk("match_cnt", match_cnt, exp_cnt);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_cnt", match_cnt, 0);
        chk("rst_gnt", gnt, 0);
        @(posedge clk);
        #1;
        chk("rst_busy2", busy, 0);
        chk("rst_src", frame_src, 0);
        chk("rst_match", match, 0);
        chk("rst_ser", ser_out, 0);
        rst = 1'b1;
        exp_cnt = 0;
        exp_match = 0;
        pend_match = 0;
        rr = 0;
    endtask

    // mode: 0 random ticks (data scrambled mid-frame), 1 every 3rd cycle, 2 every cycle
    task automatic do_frame(input int mode, input int abort_at, input bit drop);
        int idx;
        int k;
        int cyc;
        bit t;
        logic [DW-1:0] b;
        logic [3:0] win;
        idx = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (idx < 0 && req[(rr + i) % NREQ]) idx = (rr + i) % NREQ;
        end
        if (idx < 0) idx = 0;
        b = data_flat[idx*DW +: DW];
        clk_step();
        rr = (idx + 1) % NREQ;
        chk("gnt", gnt, 32'(1) << idx);
        chk("frame_src", frame_src, idx);
        chk("busy_shift", busy, 1);
        if (drop) req[idx] = 1'b0;
        k = 0;
        cyc = 0;
        win = '0;
        while (k < DW) begin
            if (abort_at == k) return;
            if (mode == 0) t = 1'($urandom_range(0, 1));
            else if (mode == 1) t = (cyc % 3 == 2);
            else t = 1'b1;
            cyc++;
            tick = t;
            if (mode == 0) data_flat = {$urandom, $urandom};
            #1;
            chk("ser_valid", ser_valid, t);
            chk("ser_out", ser_out, b[DW-1-k]);
            if (t) begin
                win = {win[2:0], b[DW-1-k]};
                if (k >= 3 && win == 4'b1101) pend_match = 1;
                k++;
            end
            clk_step();
            chk("gnt_pulse", gnt, 0);
            tick = 1'b0;
        end
        chk("frame_done", frame_done, 1);
        chk("busy_done", busy, 1);
        tick = 1'($urandom_range(0, 1));
        clk_step();
        tick = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_done", frame_done, 0);
    endtask

    initial begin
        #12;
        chk("init_gnt", gnt, 0);
        chk("init_busy", busy, 0);
        chk("init_valid", ser_valid, 0);
        chk("init_cnt", match_cnt, 0);
        do_reset();

        tick = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("idle_tick_valid", ser_valid, 0);
            chk("idle_tick_busy", busy, 0);
            clk_step();
        end
        tick = 1'b0;

        req = 4'b0001;
        data_flat[7:0] = 8'hD1;
        do_frame(1, -1, 1);
        chk("cnt_d1", match_cnt, 1);

        req = 4'b0001;
        data_flat[7:0] = 8'hDA;
        do_frame(0, -1, 1);
        chk("cnt_da", match_cnt, 3);

        req = 4'b0001;
        data_flat[7:0] = 8'h0D;
        do_frame(1, -1, 1);
        chk("cnt_0d", match_cnt, 4);

        do_reset();
        req = 4'b1111;
        data_flat = {NREQ{8'hFF}};
        for (int i = 0; i < 5; i++) begin
            do_frame(2, -1, 0);
            chk("rr_all_src", frame_src, i % NREQ);
        end
        chk("cnt_ff", match_cnt, 0);

        do_reset();
        req = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            do_frame(2, -1, 0);
            chk("rr_1010_src", frame_src, (i == 1) ? 3 : 1);
        end

        do_reset();
        req = 4'b0001;
        data_flat[7:0] = 8'h06;
        do_frame(2, -1, 0);
        data_flat[7:0] = 8'hD0;
        do_frame(2, -1, 1);
        chk("cross_frame_cnt", match_cnt, 1);

        clr_on_match = 1;
        req = 4'b0001;
        data_flat[7:0] = 8'hD1;
        do_frame(1, -1, 1);
        clr_on_match = 0;
        chk("clr_wins", match_cnt, 0);

        req = 4'b0001;
        data_flat[7:0] = 8'hD1;
        do_frame(2, 3, 0);
        do_reset();
        do_frame(2, -1, 1);
        chk("regrant_src", frame_src, 0);

        req = 4'b0001;
        data_flat[7:0] = 8'hDA;
        for (int i = 0; i < 128; i++) do_frame(2, -1, 0);
        req = 4'b0000;
        data_flat[7:0] = 8'hD1;
        req = 4'b0001;
        do_frame(2, -1, 1);
        clk_step();
        chk("sat_cnt", match_cnt, 255);

        for (int i = 0; i < 24; i++) begin
            req = 4'($urandom_range(1, 15));
            data_flat = {$urandom, $urandom};
            do_frame(i % 3, -1, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
